// File: rtl/cr_wb_seq_if.sv
// Request/writeback bundle for the capability-register writeback sequencer.
// The slave side is the sequencer; the master side feeds requests and observes CR writes.
interface cr_wb_seq_if #(
    parameter int unsigned CR_IDX_W = 2,
    parameter int unsigned ADDR_W   = 48,
    parameter int unsigned META_W   = 24
);
    logic                       iw_req_valid;
    logic                       ow_req_ready;
    logic [CR_IDX_W-1:0]        iw_req_cr;
    logic [4:0]                 iw_req_mask;
    logic [ADDR_W-1:0]          iw_req_base;
    logic [ADDR_W-1:0]          iw_req_len;
    logic [ADDR_W-1:0]          iw_req_cur;
    logic [META_W-1:0]          iw_req_perms;
    logic [META_W-1:0]          iw_req_attr;
    logic                       iw_req_tag;
    logic                       or_wr_en;
    logic [CR_IDX_W-1:0]        or_wr_cr;
    logic [2:0]                 or_wr_field;
    logic [ADDR_W-1:0]          or_wr_data;
    logic                       or_done;
    logic [(2**CR_IDX_W)-1:0]   or_busy_mask;

    modport slave (
        input  iw_req_valid, iw_req_cr, iw_req_mask, iw_req_base, iw_req_len,
               iw_req_cur, iw_req_perms, iw_req_attr, iw_req_tag,
        output ow_req_ready, or_wr_en, or_wr_cr, or_wr_field, or_wr_data,
               or_done, or_busy_mask
    );

    modport master (
        output iw_req_valid, iw_req_cr, iw_req_mask, iw_req_base, iw_req_len,
               iw_req_cur, iw_req_perms, iw_req_attr, iw_req_tag,
        input  ow_req_ready, or_wr_en, or_wr_cr, or_wr_field, or_wr_data,
               or_done, or_busy_mask
    );
endinterface

// File: rtl/cr_wb_seq.sv
// Capability-register writeback sequencer: queues full-capability writes and retires them
// one field per cycle (BASE, LEN, CUR, META, TAG) so TAG always lands after the bounds.
module cr_wb_seq #(
    parameter int unsigned CR_IDX_W = 2,
    parameter int unsigned ADDR_W   = 48,
    parameter int unsigned META_W   = 24,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        iw_clk,
    input  logic        iw_rst,
    cr_wb_seq_if.slave  bus
);
    localparam int unsigned NCR   = 2 ** CR_IDX_W;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned NFLD  = 5;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [2:0] F_BASE = 3'd0;
    localparam logic [2:0] F_LEN  = 3'd1;
    localparam logic [2:0] F_CUR  = 3'd2;
    localparam logic [2:0] F_META = 3'd3;
    localparam logic [2:0] F_TAG  = 3'd4;

    typedef struct packed {
        logic [CR_IDX_W-1:0] cr;
        logic [NFLD-1:0]     mask;
        logic [ADDR_W-1:0]   base;
        logic [ADDR_W-1:0]   len;
        logic [ADDR_W-1:0]   cur;
        logic [META_W-1:0]   perms;
        logic [META_W-1:0]   attr;
        logic                tag;
    } req_t;

    req_t               fifo_q [DEPTH];
    req_t               fifo_d [DEPTH];
    logic [DEPTH-1:0]   vld_q, vld_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;

    logic [0:0]         state_q, state_d;
    logic [NFLD-1:0]    rem_q, rem_d;
    logic               wr_en_q, wr_en_d;
    logic [CR_IDX_W-1:0] wr_cr_q, wr_cr_d;
    logic [2:0]         wr_field_q, wr_field_d;
    logic [ADDR_W-1:0]  wr_data_q, wr_data_d;
    logic               done_q, done_d;
    logic [NCR-1:0]     busy_q, busy_d;

    logic               full_c, empty_c, ready_c, push_c, pop_c;
    req_t               head_c, in_c;
    logic [2:0]         fld_c;
    logic [NFLD-1:0]    rem_clr_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_c   = &vld_q;
    assign empty_c  = ~|vld_q;
    assign ready_c  = !full_c && !iw_rst;
    assign push_c   = bus.iw_req_valid && ready_c;
    assign pop_c    = done_d;
    assign head_c   = fifo_q[rd_ptr_q];

    assign in_c = '{cr:    bus.iw_req_cr,    mask:  bus.iw_req_mask,
                    base:  bus.iw_req_base,  len:   bus.iw_req_len,
                    cur:   bus.iw_req_cur,   perms: bus.iw_req_perms,
                    attr:  bus.iw_req_attr,  tag:   bus.iw_req_tag};

    // FIFO storage and pointers; busy mask reflects every occupied slot, head included
    always_comb begin
        fifo_d   = fifo_q;
        vld_d    = vld_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        busy_d   = '0;
        if (pop_c) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = ptr_inc(rd_ptr_q);
        end
        if (push_c) begin
            fifo_d[wr_ptr_q] = in_c;
            vld_d[wr_ptr_q]  = 1'b1;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end
        for (int j = 0; j < int'(DEPTH); j++) begin
            if (vld_q[j]) busy_d[fifo_q[j].cr] = 1'b1;
        end
    end

    // Lowest pending field of the head request
    always_comb begin
        fld_c = F_BASE;
        for (int i = int'(NFLD) - 1; i >= 0; i--) begin
            if (rem_q[i]) fld_c = 3'(i);
        end
        rem_clr_c = rem_q & ~(NFLD'(1) << fld_c);
    end

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        wr_en_d    = 1'b0;
        wr_cr_d    = '0;
        wr_field_d = '0;
        wr_data_d  = '0;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty_c) begin
                    rem_d   = head_c.mask;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (rem_q == '0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wr_en_d    = 1'b1;
                    wr_cr_d    = head_c.cr;
                    wr_field_d = fld_c;
                    case (fld_c)
                        F_BASE:  wr_data_d = head_c.base;
                        F_LEN:   wr_data_d = head_c.len;
                        F_CUR:   wr_data_d = head_c.cur;
                        F_META:  wr_data_d = ADDR_W'({head_c.perms, head_c.attr});
                        F_TAG:   wr_data_d = ADDR_W'(head_c.tag);
                        default: wr_data_d = '0;
                    endcase
                    rem_d = rem_clr_c;
                    if (rem_clr_c == '0) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            state_q    <= S_IDLE;
            rem_q      <= '0;
            vld_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            wr_en_q    <= 1'b0;
            wr_cr_q    <= '0;
            wr_field_q <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            busy_q     <= '0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            vld_q      <= vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_en_q    <= wr_en_d;
            wr_cr_q    <= wr_cr_d;
            wr_field_q <= wr_field_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    // Payload slots carry no reset; occupancy is tracked by vld_q
    always_ff @(posedge iw_clk) begin
        for (int j = 0; j < int'(DEPTH); j++) fifo_q[j] <= fifo_d[j];
    end

    assign bus.ow_req_ready = ready_c;
    assign bus.or_wr_en     = wr_en_q;
    assign bus.or_wr_cr     = wr_cr_q;
    assign bus.or_wr_field  = wr_field_q;
    assign bus.or_wr_data   = wr_data_q;
    assign bus.or_done      = done_q;
    assign bus.or_busy_mask = busy_q;
endmodule
